gpr_wb_scheduler: RTL and testbench
===================================

# gpr_wb_scheduler

Shares the single GPR write port between the in-order pipeline write-back (MEM/WB) and the long-latency unit (LLU: divider and multi-cycle load return). It holds one LLU result in a buffer until the port is free, and forces a pipeline bubble if that result waits too long. It also keeps a 32-entry busy scoreboard so that ID stalls on RAW and WAW hazards against outstanding LLU destinations. It sits between MEM/WB, the LLU, ID and the GPR write port.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a buffered LLU result may wait before pipe_hold is forced; legal range 1..15.

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- wb_we  in  1  pipeline write-back enable
- wb_addr  in  5  pipeline write-back register
- wb_data  in  32  pipeline write-back data
- llu_valid  in  1  LLU result valid
- llu_addr  in  5  LLU destination register
- llu_data  in  32  LLU result data
- llu_ready  out  1  buffer can accept an LLU result
- iss_ll  in  1  ID issues a long-latency op this cycle (asserted only when id_stall=0)
- iss_rd  in  5  destination of the issued long-latency op
- id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  operands and destination of the instruction in ID
- id_rd_we  in  1  instruction in ID writes id_rd_addr
- id_stall  out  1  ID must stall (combinational)
- pipe_hold  out  1  freeze MEM/WB this cycle and re-present the same wb_* next cycle
- reg_write_en  out  1  GPR write enable
- write_reg_addr  out  5  GPR write address
- write_data  out  32  GPR write data

## Operation
- **Buffer.** One entry holding buf_valid, buf_addr and buf_data.
  - llu_ready = rst & ~buf_valid.
  - A transfer happens when llu_valid & llu_ready; the entry is captured at the clock edge.
- **Write port.** A combinational mux.
  - In ST_FORCE: drive the buffer, and ignore wb_*.
  - Otherwise, if wb_we: drive wb_*. WB has priority.
  - Otherwise, if buf_valid: drive the buffer. This is a "drain".
  - Otherwise: reg_write_en=0, addr=0, data=0.
- **FSM states.**
  - ST_IDLE: buffer empty.
  - ST_HELD: buffer full, waiting for the port.
  - ST_FORCE: buffer is forced onto the port.
- **FSM transitions.**
  - IDLE→HELD on an LLU transfer.
  - HELD→IDLE on a drain; clear wait_cnt.
  - HELD, wb_we=1: wait_cnt+1. When wait_cnt reaches STARVE_LIMIT, go to FORCE.
  - FORCE: pipe_hold=1, drain the buffer, go to IDLE next cycle.
  - A new LLU transfer is never accepted in the same cycle as a drain, because llu_ready is 0 while the buffer is full.
- **wait_cnt.** 4 bits, saturating, reset to 0.
- **Scoreboard.**
  - busy[r] is set on iss_ll with iss_rd=r≠0.
  - busy[r] is cleared on a drain with buf_addr=r.
  - Register 0 is never busy. Set wins over clear on a same-cycle conflict.
- **id_stall.** Asserted when any of these is true:
  - busy[id_rs_addr]
  - busy[id_rt_addr]
  - id_rd_we & busy[id_rd_addr]
- **Address 0.** A drain with buf_addr=0 still pulses reg_write_en; the GPR discards it.
- **Reset (rst=0, including mid-operation).** The buffer is discarded, all busy bits clear, wait_cnt=0 and the FSM goes to ST_IDLE. All outputs are 0 while rst=0.

## Timing
- WB path latency: 0 cycles; wb_* appears on the port in the same cycle.
- LLU path: a transfer at edge N gives the earliest drain in cycle N+1.
  - The busy bit clears at edge N+2.
  - ID sees the operand unstalled in cycle N+2, one cycle after the GPR write.
- Worst-case LLU wait after capture: STARVE_LIMIT+1 cycles; pipe_hold lasts exactly one cycle.
- iss_ll at edge M: busy is visible to id_stall from cycle M+1.

## Structure
- define.v holds the constants: ST_IDLE=2'd0, ST_HELD=2'd1, ST_FORCE=2'd2, REG_ADDR_W=5, and DATA_W=32 (reuses `RegBus).
- One sub-module, gpr_scoreboard: 32 busy flops with set port (iss), clear port (drain) and three combinational lookup ports. The arbiter, buffer and FSM stay in the top module.

## Test plan
- **Idle drain.** rst=0 for 2 cycles, then rst=1; iss_ll rd=5; LLU transfer addr 5, data 0xDEADBEEF; wb_we=0 → the next cycle has reg_write_en=1, addr 5, data 0xDEADBEEF; busy[5] clears the following cycle.
- **RAW stall.** busy[8] set; ID rs=8 → id_stall=1 until the cycle after the drain of reg 8; rt=8 and rd_we/rd=8 behave the same.
- **Starvation.** Buffer full with addr 3; wb_we=1 continuously → pipe_hold=1 in HELD cycle 5 (STARVE_LIMIT=4), the port carries addr 3 while wb_* is ignored, then pipe_hold=0 and WB resumes.
- **Contention.** wb_we=1 (addr 9, 0x11) in the cycle after an LLU transfer (addr 10, 0x22) → the port carries 9/0x11; the next cycle with wb_we=0 carries 10/0x22; llu_ready=0 throughout.
- **Reset mid-operation.** Buffer full and busy[12] set; rst=0 for one cycle → llu_ready and reg_write_en are 0, busy is empty and the FSM is IDLE; no stale write ever appears.
- **Register zero.** iss_ll rd=0 → no stall on rs=0; the drain to addr 0 pulses reg_write_en and no busy bit changes.

Source files
------------

// File: rtl/gpr_wb_scheduler_pkg.sv
// Shared constants and types for the GPR write-back scheduler.
package gpr_wb_scheduler_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } sched_state_e;

    // One buffered long-latency result waiting for the GPR write port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } llu_entry_t;

endpackage

// File: rtl/gpr_wb_scheduler_scoreboard.sv
// Busy bits for outstanding long-latency destinations, with three ID lookups.
module gpr_wb_scheduler_scoreboard
    import gpr_wb_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rs_busy_c,
    output logic                  rt_busy_c,
    output logic                  rd_busy_c
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Next busy vector: clear on drain, then set on issue so set wins; r0 never busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rs_busy_c = busy[rs_addr];
    assign rt_busy_c = busy[rt_addr];
    assign rd_busy_c = busy[rd_addr];

endmodule

// File: rtl/gpr_wb_scheduler.sv
// Arbitrates the GPR write port between MEM/WB and a one-entry LLU buffer,
// forcing a pipeline bubble when the buffered result starves.
module gpr_wb_scheduler
    import gpr_wb_scheduler_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  llu_valid,
    input  logic [REG_ADDR_W-1:0] llu_addr,
    input  logic [DATA_W-1:0]     llu_data,
    output logic                  llu_ready,
    input  logic                  iss_ll,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_rd_we,
    output logic                  id_stall,
    output logic                  pipe_hold,
    output logic                  reg_write_en,
    output logic [REG_ADDR_W-1:0] write_reg_addr,
    output logic [DATA_W-1:0]     write_data
);

    // Last wait count that still leaves the result in HELD.
    localparam logic [CNT_W-1:0] FORCE_AT = CNT_W'(STARVE_LIMIT - 1);

    sched_state_e     state;
    sched_state_e     state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_nxt;
    llu_entry_t       buf_q;
    logic             buf_valid_c;
    logic             llu_fire_c;
    logic             drain_c;
    logic             rs_busy_c;
    logic             rt_busy_c;
    logic             rd_busy_c;

    // The buffer is full exactly when the FSM is out of IDLE.
    assign buf_valid_c = (state != ST_IDLE);
    assign llu_ready   = rst & ~buf_valid_c;
    assign llu_fire_c  = llu_valid & llu_ready;

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // LLU result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q <= '0;
        end else if (llu_fire_c) begin
            buf_q <= llu_entry_t'({llu_addr, llu_data});
        end
    end

    // Next state, starvation count and write-port mux; everything is quiet in reset.
    always_comb begin
        state_nxt      = state;
        wait_nxt       = wait_cnt;
        drain_c        = 1'b0;
        pipe_hold      = 1'b0;
        reg_write_en   = 1'b0;
        write_reg_addr = '0;
        write_data     = '0;
        if (rst) begin
            unique case (state)
                ST_IDLE: begin
                    if (wb_we) begin
                        reg_write_en   = 1'b1;
                        write_reg_addr = wb_addr;
                        write_data     = wb_data;
                    end
                    if (llu_fire_c) begin
                        state_nxt = ST_HELD;
                        wait_nxt  = '0;
                    end
                end
                ST_HELD: begin
                    reg_write_en = 1'b1;
                    if (wb_we) begin
                        write_reg_addr = wb_addr;
                        write_data     = wb_data;
                        if (wait_cnt != '1) begin
                            wait_nxt = wait_cnt + CNT_W'(1);
                        end
                        if (wait_cnt == FORCE_AT) begin
                            state_nxt = ST_FORCE;
                        end
                    end else begin
                        drain_c        = 1'b1;
                        write_reg_addr = buf_q.addr;
                        write_data     = buf_q.data;
                        state_nxt      = ST_IDLE;
                        wait_nxt       = '0;
                    end
                end
                ST_FORCE: begin
                    pipe_hold      = 1'b1;
                    drain_c        = 1'b1;
                    reg_write_en   = 1'b1;
                    write_reg_addr = buf_q.addr;
                    write_data     = buf_q.data;
                    state_nxt      = ST_IDLE;
                    wait_nxt       = '0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    wait_nxt  = '0;
                end
            endcase
        end
    end

    gpr_wb_scheduler_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_ll),
        .set_addr  (iss_rd),
        .clr_en    (drain_c),
        .clr_addr  (buf_q.addr),
        .rs_addr   (id_rs_addr),
        .rt_addr   (id_rt_addr),
        .rd_addr   (id_rd_addr),
        .rs_busy_c (rs_busy_c),
        .rt_busy_c (rt_busy_c),
        .rd_busy_c (rd_busy_c)
    );

    // RAW on either source, or WAW on a written destination.
    assign id_stall = rst & (rs_busy_c | rt_busy_c | (id_rd_we & rd_busy_c));

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Self-checking bench for gpr_wb_scheduler: directed scenarios plus random
// traffic, all checked against a queue-based behavioural model.
module tb_gpr_wb_scheduler;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        llu_valid;
    logic [4:0]  llu_addr;
    logic [31:0] llu_data;
    logic        llu_ready;
    logic        iss_ll;
    logic [4:0]  iss_rd;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        id_stall;
    logic        pipe_hold;
    logic        reg_write_en;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_data;

    gpr_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .llu_valid      (llu_valid),
        .llu_addr       (llu_addr),
        .llu_data       (llu_data),
        .llu_ready      (llu_ready),
        .iss_ll         (iss_ll),
        .iss_rd         (iss_rd),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rd_addr     (id_rd_addr),
        .id_rd_we       (id_rd_we),
        .id_stall       (id_stall),
        .pipe_hold      (pipe_hold),
        .reg_write_en   (reg_write_en),
        .write_reg_addr (write_reg_addr),
        .write_data     (write_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending LLU results, cycles lost to WB, busy set.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        m_bq[$];
    int          m_lost;
    bit   [31:0] m_busy;
    bit          m_force;
    bit          m_drain;
    bit          m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        return rst && (m_busy[id_rs_addr] || m_busy[id_rt_addr] ||
                       (id_rd_we && m_busy[id_rd_addr]));
    endfunction

    // Compare every output against the model for the inputs now applied.
    task automatic settle_and_check();
        bit          full;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        #1;
        full    = (m_bq.size() != 0);
        m_force = rst && full && (m_lost == LIMIT);
        m_drain = rst && full && (m_force || !wb_we);
        m_ready = rst && !full;
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        if (rst) begin
            if (m_drain) begin
                e_we   = 1'b1;
                e_addr = m_bq[0].addr;
                e_data = m_bq[0].data;
            end else if (wb_we) begin
                e_we   = 1'b1;
                e_addr = wb_addr;
                e_data = wb_data;
            end
        end
        check_eq("llu_ready", 32'(llu_ready), 32'(m_ready));
        check_eq("pipe_hold", 32'(pipe_hold), 32'(m_force));
        check_eq("id_stall", 32'(id_stall), 32'(model_stall()));
        check_eq("reg_write_en", 32'(reg_write_en), 32'(e_we));
        check_eq("write_reg_addr", 32'(write_reg_addr), 32'(e_addr));
        check_eq("write_data", write_data, e_data);
    endtask

    // Apply the clock edge to the model.
    task automatic model_update();
        ent_t e;
        if (!rst) begin
            m_bq.delete();
            m_lost = 0;
            m_busy = '0;
        end else begin
            if (m_drain) begin
                m_busy[m_bq[0].addr] = 1'b0;
                m_bq.delete();
                m_lost = 0;
            end else if (m_bq.size() != 0) begin
                m_lost++;
            end
            if (llu_valid && m_ready) begin
                e.addr = llu_addr;
                e.data = llu_data;
                m_bq.push_back(e);
                m_lost = 0;
            end
            if (iss_ll && iss_rd != 5'd0) begin
                m_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        settle_and_check();
        advance();
    endtask

    task automatic drive_quiet();
        rst        = 1'b1;
        wb_we      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        llu_valid  = 1'b0;
        llu_addr   = '0;
        llu_data   = '0;
        iss_ll     = 1'b0;
        iss_rd     = '0;
        id_rs_addr = '0;
        id_rt_addr = '0;
        id_rd_addr = '0;
        id_rd_we   = 1'b0;
    endtask

    task automatic drive_random(input int wb_pct);
        rst        = ($urandom_range(0, 299) != 0);
        wb_we      = ($urandom_range(0, 99) < wb_pct);
        wb_addr    = 5'($urandom_range(0, 7));
        wb_data    = $urandom();
        llu_valid  = ($urandom_range(0, 1) == 1);
        llu_addr   = 5'($urandom_range(0, 7));
        llu_data   = $urandom();
        id_rs_addr = 5'($urandom_range(0, 7));
        id_rt_addr = 5'($urandom_range(0, 7));
        id_rd_addr = 5'($urandom_range(0, 7));
        id_rd_we   = ($urandom_range(0, 1) == 1);
        iss_rd     = 5'($urandom_range(0, 7));
        iss_ll     = ($urandom_range(0, 3) == 0) && !model_stall();
    endtask

    initial begin
        m_lost = 0;
        m_busy = '0;
        drive_quiet();
        rst = 1'b0;
        @(negedge clk);
        step();
        step();
        drive_quiet();

        // Idle drain: issue rd=5, transfer, drain next cycle, unstall after.
        iss_ll = 1'b1; iss_rd = 5'd5;
        step();
        iss_ll = 1'b0; id_rs_addr = 5'd5;
        llu_valid = 1'b1; llu_addr = 5'd5; llu_data = 32'hDEADBEEF;
        settle_and_check();
        check_eq("idle_stall_pre", 32'(id_stall), 32'd1);
        advance();
        llu_valid = 1'b0;
        settle_and_check();
        check_eq("idle_drain_we", 32'(reg_write_en), 32'd1);
        check_eq("idle_drain_addr", 32'(write_reg_addr), 32'd5);
        check_eq("idle_drain_data", write_data, 32'hDEADBEEF);
        check_eq("idle_stall_drain", 32'(id_stall), 32'd1);
        advance();
        settle_and_check();
        check_eq("idle_stall_post", 32'(id_stall), 32'd0);
        advance();
        drive_quiet();

        // Starvation: buffered addr 3 with WB busy every cycle.
        llu_valid = 1'b1; llu_addr = 5'd3; llu_data = 32'h33;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
        step();
        llu_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            settle_and_check();
            check_eq($sformatf("starve_hold_%0d", k), 32'(pipe_hold), 32'(k == 5));
            check_eq($sformatf("starve_addr_%0d", k), 32'(write_reg_addr), (k == 5) ? 32'd3 : 32'd1);
            check_eq($sformatf("starve_ready_%0d", k), 32'(llu_ready), 32'(k == 6));
            advance();
        end
        drive_quiet();

        // Contention: WB first, then the buffered result.
        llu_valid = 1'b1; llu_addr = 5'd10; llu_data = 32'h22;
        step();
        llu_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h11;
        settle_and_check();
        check_eq("cont_wb_addr", 32'(write_reg_addr), 32'd9);
        check_eq("cont_wb_data", write_data, 32'h11);
        check_eq("cont_ready_a", 32'(llu_ready), 32'd0);
        advance();
        wb_we = 1'b0;
        settle_and_check();
        check_eq("cont_llu_addr", 32'(write_reg_addr), 32'd10);
        check_eq("cont_llu_data", write_data, 32'h22);
        check_eq("cont_ready_b", 32'(llu_ready), 32'd0);
        advance();
        drive_quiet();

        // Reset mid-operation with a full buffer and busy[12].
        iss_ll = 1'b1; iss_rd = 5'd12;
        step();
        iss_ll = 1'b0;
        llu_valid = 1'b1; llu_addr = 5'd12; llu_data = 32'hC0FFEE;
        wb_we = 1'b1; wb_addr = 5'd2;
        step();
        llu_valid = 1'b0; rst = 1'b0;
        settle_and_check();
        check_eq("rst_ready", 32'(llu_ready), 32'd0);
        check_eq("rst_we", 32'(reg_write_en), 32'd0);
        advance();
        rst = 1'b1; wb_we = 1'b0; id_rs_addr = 5'd12;
        settle_and_check();
        check_eq("rst_no_stale", 32'(reg_write_en), 32'd0);
        check_eq("rst_busy_gone", 32'(id_stall), 32'd0);
        check_eq("rst_ready_back", 32'(llu_ready), 32'd1);
        advance();
        drive_quiet();

        // Register zero: never busy, drain still writes.
        iss_ll = 1'b1; iss_rd = 5'd0;
        step();
        iss_ll = 1'b0;
        llu_valid = 1'b1; llu_addr = 5'd0; llu_data = 32'h5A5A;
        settle_and_check();
        check_eq("r0_no_stall", 32'(id_stall), 32'd0);
        advance();
        llu_valid = 1'b0;
        settle_and_check();
        check_eq("r0_drain_we", 32'(reg_write_en), 32'd1);
        check_eq("r0_drain_addr", 32'(write_reg_addr), 32'd0);
        advance();

        // Random traffic at light, medium and saturating WB load.
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1000; c++) begin
                drive_random((ph == 0) ? 10 : (ph == 1) ? 50 : 95);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
